// File: rtl/replay_pkg.sv
// Shared definitions for the replay issue controller: parameter defaults,
// FSM state encoding and counter-width derivations.
package replay_pkg;

    localparam int DATA_W_DEF    = 16;
    localparam int BACKOFF_DEF   = 3;
    localparam int MAX_RETRY_DEF = 7;
    localparam int CNT_W_DEF     = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_BACKOFF = 2'd2
    } state_e;

    // Bits needed to hold values 0..max_val, never less than one bit.
    function automatic int min_cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

    // Width of the per-request retry counter.
    function automatic int retry_width(input int max_retry);
        return min_cnt_width(max_retry);
    endfunction

    // Width of the backoff down-counter.
    function automatic int backoff_width(input int backoff);
        return min_cnt_width(backoff);
    endfunction

endpackage

// File: rtl/replay_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, never wraps.
module replay_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_r;

    // Count increments until the all-ones ceiling is reached.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= {W{1'b0}};
        end else if (inc && (count_r != {W{1'b1}})) begin
            count_r <= count_r + W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/replay_issue_ctrl.sv
// Replay issue controller: holds one request, issues it to a replay-check
// stage, backs off and re-issues on replay, and drops it after too many
// retries. Successful requests complete with a one-cycle done pulse.
module replay_issue_ctrl
    import replay_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BACKOFF   = BACKOFF_DEF,
    parameter int MAX_RETRY = MAX_RETRY_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              io_in_valid,
    output logic              io_in_ready,
    input  logic [DATA_W-1:0] io_in_bits,
    output logic              io_valid,
    output logic [DATA_W-1:0] io_bits,
    input  logic              io_replay,
    output logic              io_done_valid,
    output logic [DATA_W-1:0] io_done_bits,
    output logic              io_drop,
    output logic              io_busy,
    output logic [CNT_W-1:0]  io_replay_count
);

    localparam int RETRY_W = retry_width(MAX_RETRY);
    localparam int BO_W    = backoff_width(BACKOFF);
    localparam logic [RETRY_W-1:0] MAX_RETRY_C = RETRY_W'(MAX_RETRY);
    localparam logic [BO_W-1:0]    BACKOFF_C   = BO_W'(BACKOFF);

    state_e              state_r;
    logic [DATA_W-1:0]   hold_r;
    logic [RETRY_W-1:0]  retry_r;
    logic [BO_W-1:0]     bo_cnt_r;
    logic                valid_r;
    logic                busy_r;
    logic                done_valid_r;
    logic [DATA_W-1:0]   done_bits_r;
    logic                drop_r;

    logic                in_ready_s;
    logic                accept_s;
    logic                replay_hit_s;

    // Ready in IDLE, and in ISSUE when the current issue completes this cycle.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_r)
            ST_IDLE:  in_ready_s = 1'b1;
            ST_ISSUE: in_ready_s = ~io_replay;
            default:  in_ready_s = 1'b0;
        endcase
    end

    assign accept_s     = io_in_valid & in_ready_s;
    assign replay_hit_s = (state_r == ST_ISSUE) & io_replay;

    // Main FSM with registered issue/busy/done/drop outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            hold_r       <= {DATA_W{1'b0}};
            retry_r      <= {RETRY_W{1'b0}};
            bo_cnt_r     <= {BO_W{1'b0}};
            valid_r      <= 1'b0;
            busy_r       <= 1'b0;
            done_valid_r <= 1'b0;
            done_bits_r  <= {DATA_W{1'b0}};
            drop_r       <= 1'b0;
        end else begin
            done_valid_r <= 1'b0;
            drop_r       <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        hold_r  <= io_in_bits;
                        retry_r <= {RETRY_W{1'b0}};
                        state_r <= ST_ISSUE;
                        valid_r <= 1'b1;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        valid_r <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    if (!io_replay) begin
                        // Success: complete now, optionally take the next request.
                        done_valid_r <= 1'b1;
                        done_bits_r  <= hold_r;
                        if (accept_s) begin
                            hold_r  <= io_in_bits;
                            retry_r <= {RETRY_W{1'b0}};
                            state_r <= ST_ISSUE;
                            valid_r <= 1'b1;
                            busy_r  <= 1'b1;
                        end else begin
                            state_r <= ST_IDLE;
                            valid_r <= 1'b0;
                            busy_r  <= 1'b0;
                        end
                    end else if (retry_r < MAX_RETRY_C) begin
                        retry_r <= retry_r + RETRY_W'(1);
                        if (BACKOFF == 0) begin
                            // No idle gap: re-issue straight away.
                            state_r <= ST_ISSUE;
                            valid_r <= 1'b1;
                            busy_r  <= 1'b1;
                        end else begin
                            state_r  <= ST_BACKOFF;
                            bo_cnt_r <= BACKOFF_C;
                            valid_r  <= 1'b0;
                            busy_r   <= 1'b1;
                        end
                    end else begin
                        // Retry budget exhausted: abandon the request.
                        drop_r  <= 1'b1;
                        state_r <= ST_IDLE;
                        valid_r <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                end
                ST_BACKOFF: begin
                    busy_r <= 1'b1;
                    if (bo_cnt_r <= BO_W'(1)) begin
                        state_r  <= ST_ISSUE;
                        bo_cnt_r <= {BO_W{1'b0}};
                        valid_r  <= 1'b1;
                    end else begin
                        state_r  <= ST_BACKOFF;
                        bo_cnt_r <= bo_cnt_r - BO_W'(1);
                        valid_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    replay_sat_counter #(
        .W (CNT_W)
    ) u_replay_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (replay_hit_s),
        .count (io_replay_count)
    );

    assign io_in_ready   = in_ready_s;
    assign io_valid      = valid_r;
    assign io_bits       = hold_r;
    assign io_done_valid = done_valid_r;
    assign io_done_bits  = done_bits_r;
    assign io_drop       = drop_r;
    assign io_busy       = busy_r;

endmodule

// File: doc/replay_issue_ctrl.md
REPLAY_ISSUE_CTRL -- requirements
Module: replay_issue_ctrl

Interface
REQ-001 The block SHALL have these parameters: DATA_W, default 16, request payload width; BACKOFF, default 3, idle cycles between a replay and the re-issue; MAX_RETRY, default 7, number of re-issues allowed before a drop; CNT_W, default 16, width of the statistics counter.
REQ-002 The block SHALL have these ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high.
- io_in_valid  in  1  upstream request present.
- io_in_ready  out  1  block accepts the request this cycle.
- io_in_bits  in  DATA_W  request payload.
- io_valid  out  1  issue strobe to the replay-check stage.
- io_bits  out  DATA_W  payload being issued.
- io_replay  in  1  same-cycle replay verdict from the check stage; meaningful only while io_valid=1.
- io_done_valid  out  1  one-cycle pulse, request completed.
- io_done_bits  out  DATA_W  payload of the completed request.
- io_drop  out  1  one-cycle pulse, request abandoned.
- io_busy  out  1  a request is held.
- io_replay_count  out  CNT_W  saturating total of replays seen.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, ISSUE and BACKOFF.
REQ-004 io_in_ready SHALL be 1 in IDLE, 1 in ISSUE when io_replay=0, and 0 otherwise; the combinational path io_replay -> io_in_ready is intended.
REQ-005 An accept (io_in_valid & io_in_ready) SHALL capture io_in_bits into the hold register, clear the retry counter and enter ISSUE next cycle (one-cycle accept-to-issue latency).
REQ-006 In ISSUE, io_valid SHALL be 1 and io_bits SHALL equal the hold register; io_valid SHALL be 0 in IDLE and BACKOFF.
REQ-007 ISSUE with io_replay=0 (success): io_done_valid=1 and io_done_bits=held payload in the following cycle. The next state SHALL be ISSUE if an accept occurs in the same cycle, else IDLE; back-to-back throughput is one request per cycle.
REQ-008 ISSUE with io_replay=1 and retry counter < MAX_RETRY SHALL increment the retry counter. The block SHALL then enter BACKOFF with the backoff counter loaded with BACKOFF; if BACKOFF=0 it SHALL remain in ISSUE and re-issue next cycle.
REQ-009 BACKOFF SHALL last exactly BACKOFF cycles and then return to ISSUE with the same payload.
REQ-010 ISSUE with io_replay=1 and retry counter = MAX_RETRY SHALL pulse io_drop in the following cycle, enter IDLE and not pulse io_done_valid.
REQ-011 Every ISSUE cycle with io_replay=1 SHALL increment io_replay_count, saturating at all-ones with no wrap.
REQ-012 io_busy SHALL be 1 in ISSUE and BACKOFF and 0 in IDLE.
REQ-013 io_done_valid and io_drop SHALL never both be 1 in the same cycle; io_done_bits SHALL hold its last value when io_done_valid=0.
REQ-014 The retry counter SHALL be ceil(log2(MAX_RETRY+1)) bits wide; the backoff counter SHALL be ceil(log2(BACKOFF+1)) bits wide, minimum 1.

Reset
REQ-015 Asserting reset at any time, including mid-ISSUE or mid-BACKOFF, SHALL immediately force: state=IDLE; io_valid, io_done_valid, io_drop and io_busy=0; retry counter, backoff counter and io_replay_count=0; hold register=0. Any held request SHALL be discarded with no drop pulse.
REQ-016 After reset deasserts, io_in_ready SHALL be 1 in the first clock cycle.

Structure
REQ-017 The FSM state encoding and the parameter defaults SHALL be defined in a shared package (replay_pkg); width derivations SHALL also live there as functions.
REQ-018 The block SHALL be a single module with one sub-module, replay_sat_counter (the parameterised saturating counter behind io_replay_count).

Verification
REQ-019 Accept 0x1234 with io_replay held at 0 -> io_valid is 1 one cycle after the accept, io_done_valid=1 with io_done_bits=0x1234 the cycle after that, and io_replay_count=0.
REQ-020 Drive io_replay=1 on the first issue only -> 3 BACKOFF cycles, re-issue, then done; io_replay_count=1.
REQ-021 Hold io_replay=1 permanently -> 8 issues total, io_drop pulses once, state returns to IDLE, and io_replay_count=8.
REQ-022 Stream 4 requests back to back with io_replay=0 -> 4 consecutive io_valid cycles and 4 consecutive done pulses, in order.
REQ-023 Assert reset during the 2nd BACKOFF cycle -> all outputs are 0 at once, no io_drop pulse, and io_in_ready=1 after reset releases.
REQ-024 Set CNT_W=2 and force 5 replays -> io_replay_count saturates at 3.
